am_popcount_argmax: RTL
=======================

Name: am_popcount_argmax

Overview:
- Parametrised next-generation associative-memory similarity engine.
- Each cycle it popcounts one DIMS_PER_CC-bit AND-array chunk through a pipelined tree adder, then accumulates chunks into a per-class similarity value.
- After each class completes, it runs a running argmax over classes and reports the best class at the end of the query.
- Sits between the AND array and the inference controller.

Parameters:
- DIMS_PER_CC, 500: bits popcounted per cycle; any value ≥2 (tree zero-pads to the next power of two).
- PIPE_STAGES, 2: register stages inside the popcount tree, 0..log2ceil(DIMS_PER_CC).
- ACC_W, 13: similarity accumulator width.
- CLASS_W, 5: class index width.

Ports:
- clk  in  1  clock.
- nrst  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush of pipeline, accumulator and argmax state.
- in_valid  in  1  and_array_out holds a valid chunk this cycle.
- in_last  in  1  chunk is the final chunk of the current class (qualified by in_valid).
- in_last_class  in  1  current class is the final class of the query (qualified by in_valid & in_last).
- in_class_id  in  CLASS_W  class index of the chunk (sampled with in_last).
- and_array_out  in  DIMS_PER_CC  AND of query and class chunk.
- sim_valid  out  1  one-cycle pulse: similarity_value/sim_class_id valid.
- similarity_value  out  ACC_W  final similarity of a completed class.
- sim_class_id  out  CLASS_W  class of similarity_value.
- sim_overflow  out  1  similarity_value saturated (valid with sim_valid).
- best_valid  out  1  one-cycle pulse: argmax result for the query is valid.
- best_class  out  CLASS_W  index of the highest-similarity class.
- best_value  out  ACC_W  similarity of best_class.

Behaviour:
- Reset (nrst=0, async):
  - All outputs 0.
  - Pipeline valid bits 0.
  - Accumulator 0.
  - Internal have_best flag 0.
- Popcount tree:
  - PW = clog2(DIMS_PER_CC+1) bits.
  - Pairwise adder tree; each level widens by 1 bit.
  - PIPE_STAGES registers are distributed as evenly as possible across levels.
  - in_valid, in_last, in_last_class and in_class_id travel alongside the data as a valid-tagged sideband.
  - No backpressure: one chunk accepted every cycle.
- Accumulate:
  - A chunk presented at cycle t reaches the accumulator at cycle t+PIPE_STAGES and is registered at that cycle's closing edge.
  - first flag is set after reset, after clear, and after every last chunk.
  - If first is set: acc <= partial. Otherwise: acc <= acc + partial, saturating at 2^ACC_W−1.
  - An internal sticky overflow flag is set on saturation and cleared together with first.
  - Bubbles (in_valid=0) hold acc.
  - Back-to-back classes with no bubble are supported.
- Similarity output:
  - When the last chunk registers, sim_valid=1 at cycle t+PIPE_STAGES+1.
  - In that cycle: similarity_value = final sum including the last chunk; sim_class_id = tagged id; sim_overflow = overflow flag.
  - similarity_value holds its value until the next sim_valid.
- Argmax (evaluated on the same edge that produces sim_valid):
  - If have_best=0 or final > best_value (strict): best_value/best_class <= final/id and have_best <= 1.
  - Ties keep the earlier class.
  - If the class was tagged in_last_class:
    - best_valid pulses together with sim_valid.
    - best_class/best_value include that final class.
    - have_best <= 0 for the next query.
    - best_* hold their values until the next update.
- Single-chunk class (in_valid & in_last on the first chunk): final = partial.
- clear:
  - Zeroes all pipeline valids, acc, first=1, have_best=0 and overflow at the next edge.
  - Chunks in flight are dropped and no sim_valid/best_valid is generated for them.
  - clear together with in_valid: clear wins and the chunk is dropped.
  - Output data registers are not zeroed by clear; only reset zeroes them.
- Reset mid-class: all state lost; no partial result is emitted.
- in_last_class without in_last: ignored.

Decomposition:
- Package am_pkg:
  - Default DIMS_PER_CC / ACC_W / CLASS_W.
  - Function clog2-based popcount width.
  - Typedef for the sideband tag struct (valid, last, last_class, class_id).
- Sub-module am_popcount_tree:
  - Parameters DIMS_PER_CC and PIPE_STAGES; tag passed through.
  - Outputs partial and the delayed tag.
- am_popcount_argmax contains the accumulator, saturation logic and argmax.

Test Plan (DIMS_PER_CC=500, PIPE_STAGES=2, ACC_W=13 unless stated):
- 10 consecutive all-ones chunks, class 3, last on chunk 10, in_last_class set:
  - sim_valid exactly 3 cycles after chunk 10.
  - similarity_value=5000, sim_class_id=3.
  - best_valid in the same cycle with best_class=3, best_value=5000.
- Three classes back-to-back (no bubbles), 2 chunks each, popcounts per class 100+50, 200+100, 200+100; last class flagged:
  - sim_valid values 150, 300, 300.
  - best_class=1 (strict tie-break), best_value=300.
- Chunks with 7 ones, bubbles inserted between every chunk, 4 chunks: result 28 with bubbles ignored; then a single-chunk class of 499 ones yields 499.
- 17 all-ones chunks in one class:
  - similarity_value=8191, sim_overflow=1.
  - Next class of 1 chunk with 5 ones gives 5 with sim_overflow=0.
- Assert clear while 2 chunks of a class are in flight:
  - No sim_valid.
  - Next class of 1 chunk with 9 ones gives 9, and argmax restarts (best_value=9 with in_last_class).
- Deassert nrst mid-class: all outputs 0 immediately; no pulses afterwards. Repeat the first scenario with PIPE_STAGES=0: latency 1 cycle, value 5000.

Source files
------------

// File: rtl/am_pkg.sv
// Shared defaults, popcount width helper and the sideband tag that rides
// alongside each chunk through the popcount tree.
package am_pkg;

  localparam int DIMS_PER_CC_DEF = 500;
  localparam int PIPE_STAGES_DEF = 2;
  localparam int ACC_W_DEF       = 13;
  localparam int CLASS_W_DEF     = 5;

  // Bits needed to hold a popcount of 0..dims.
  function automatic int pop_w(input int dims);
    return $clog2(dims + 1);
  endfunction

  // class_id is sized by the package CLASS_W; the top's CLASS_W must match it.
  typedef struct packed {
    logic                   valid;
    logic                   last;
    logic                   last_class;
    logic [CLASS_W_DEF-1:0] class_id;
  } am_tag_t;

  localparam int TAG_W = $bits(am_tag_t);

endpackage

// File: rtl/am_popcount_tree.sv
// Pairwise adder-tree popcount of one chunk; PIPE_STAGES register levels are
// spread evenly over the tree and the sideband tag is delayed to match.
module am_popcount_tree
  import am_pkg::*;
#(
  parameter int DIMS_PER_CC = DIMS_PER_CC_DEF,
  parameter int PIPE_STAGES = PIPE_STAGES_DEF,
  localparam int PW = pop_w(DIMS_PER_CC)
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   clear,
  input  logic [DIMS_PER_CC-1:0] din,
  input  logic [TAG_W-1:0]       tag_in,
  output logic [PW-1:0]          partial,
  output logic [TAG_W-1:0]       tag_out
);

  localparam int LVLS = $clog2(DIMS_PER_CC);
  localparam int N2   = 1 << LVLS;

  for (genvar k = 0; k <= LVLS; k++) begin : g_lvl
    localparam int CNT = N2 >> k;
    // Level k grows by one bit per level; the root is capped at PW since the
    // true count never exceeds DIMS_PER_CC.
    localparam int W = ((k + 1) < PW) ? (k + 1) : PW;

    logic [W-1:0] node [CNT];
    am_tag_t      tag;

    if (k == 0) begin : g_leaf
      for (genvar i = 0; i < N2; i++) begin : g_bit
        if (i < DIMS_PER_CC) begin : g_in
          assign node[i] = din[i];
        end else begin : g_pad
          assign node[i] = 1'b0;
        end
      end
      assign tag = am_tag_t'(tag_in);
    end else begin : g_node
      // A register follows level k whenever the even share k*P/L steps up.
      localparam bit REG = ((k * PIPE_STAGES) / LVLS) > (((k - 1) * PIPE_STAGES) / LVLS);

      logic [W-1:0] nxt [CNT];

      for (genvar i = 0; i < CNT; i++) begin : g_add
        assign nxt[i] = W'(g_lvl[k-1].node[2*i]) + W'(g_lvl[k-1].node[2*i+1]);
      end

      if (REG) begin : g_reg
        always_ff @(posedge clk) begin
          node <= nxt;
        end

        always_ff @(posedge clk or negedge nrst) begin
          if (!nrst) begin
            tag <= '0;
          end else if (clear) begin
            tag <= '0;
          end else begin
            tag <= g_lvl[k-1].tag;
          end
        end
      end else begin : g_comb
        assign node = nxt;
        assign tag  = g_lvl[k-1].tag;
      end
    end
  end

  assign partial = g_lvl[LVLS].node[0];
  assign tag_out = g_lvl[LVLS].tag;

endmodule

// File: rtl/am_popcount_argmax.sv
// Associative-memory similarity engine: popcount tree, saturating per-class
// accumulator and a running argmax reported at the end of each query.
module am_popcount_argmax
  import am_pkg::*;
#(
  parameter int DIMS_PER_CC = DIMS_PER_CC_DEF,
  parameter int PIPE_STAGES = PIPE_STAGES_DEF,
  parameter int ACC_W       = ACC_W_DEF,
  parameter int CLASS_W     = CLASS_W_DEF
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  logic                   in_last_class,
  input  logic [CLASS_W-1:0]     in_class_id,
  input  logic [DIMS_PER_CC-1:0] and_array_out,
  output logic                   sim_valid,
  output logic [ACC_W-1:0]       similarity_value,
  output logic [CLASS_W-1:0]     sim_class_id,
  output logic                   sim_overflow,
  output logic                   best_valid,
  output logic [CLASS_W-1:0]     best_class,
  output logic [ACC_W-1:0]       best_value
);

  localparam int PW    = pop_w(DIMS_PER_CC);
  localparam int SUM_W = ((ACC_W > PW) ? ACC_W : PW) + 1;
  localparam logic [SUM_W-1:0] ACC_MAX = {{(SUM_W - ACC_W){1'b0}}, {ACC_W{1'b1}}};

  function automatic logic sat_hit(input logic [SUM_W-1:0] s);
    return s > ACC_MAX;
  endfunction

  function automatic logic [ACC_W-1:0] sat_acc(input logic [SUM_W-1:0] s);
    return sat_hit(s) ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  am_tag_t          tag_p0;
  logic [TAG_W-1:0] tag_bits_p;
  am_tag_t          tag_p;
  logic [PW-1:0]    partial_p;

  assign tag_p0 = '{valid:      in_valid,
                    last:       in_last,
                    last_class: in_last_class,
                    class_id:   in_class_id};

  am_popcount_tree #(
    .DIMS_PER_CC (DIMS_PER_CC),
    .PIPE_STAGES (PIPE_STAGES)
  ) u_tree (
    .clk     (clk),
    .nrst    (nrst),
    .clear   (clear),
    .din     (and_array_out),
    .tag_in  (tag_p0),
    .partial (partial_p),
    .tag_out (tag_bits_p)
  );

  assign tag_p = am_tag_t'(tag_bits_p);

  logic [ACC_W-1:0] acc;
  logic             first;
  logic             ovf;
  logic             have_best;

  logic [SUM_W-1:0] sum_full;
  logic [ACC_W-1:0] final_val;
  logic             final_ovf;
  logic             take;
  logic             better;

  // Accumulate stage: tree output folds into acc on the closing edge.
  always_comb begin
    sum_full = SUM_W'(partial_p);
    if (!first) begin
      sum_full = sum_full + SUM_W'(acc);
    end
    final_val = sat_acc(sum_full);
    final_ovf = sat_hit(sum_full) | (ovf & ~first);
    take      = tag_p.valid & ~clear;
    better    = ~have_best | (final_val > best_value);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc              <= '0;
      first            <= 1'b1;
      ovf              <= 1'b0;
      have_best        <= 1'b0;
      sim_valid        <= 1'b0;
      similarity_value <= '0;
      sim_class_id     <= '0;
      sim_overflow     <= 1'b0;
      best_valid       <= 1'b0;
      best_class       <= '0;
      best_value       <= '0;
    end else begin
      sim_valid  <= 1'b0;
      best_valid <= 1'b0;
      if (clear) begin
        acc       <= '0;
        first     <= 1'b1;
        ovf       <= 1'b0;
        have_best <= 1'b0;
      end else if (take) begin
        acc <= final_val;
        if (tag_p.last) begin
          first            <= 1'b1;
          ovf              <= 1'b0;
          sim_valid        <= 1'b1;
          similarity_value <= final_val;
          sim_class_id     <= tag_p.class_id;
          sim_overflow     <= final_ovf;
          // Strict compare: a tie keeps the earlier class.
          if (better) begin
            best_value <= final_val;
            best_class <= tag_p.class_id;
          end
          have_best  <= ~tag_p.last_class;
          best_valid <= tag_p.last_class;
        end else begin
          first <= 1'b0;
          ovf   <= final_ovf;
        end
      end
    end
  end

endmodule
